miriscv_fetch_stage: RTL and testbench

Fetch stage of the miriscv pipeline. It holds the PC and issues in-order instruction memory requests over a req/gnt/rvalid interface. Returned words are buffered together with their PC and presented to the decode stage on the f_instr/f_current_pc/f_next_pc/f_valid interface. It obeys control-unit stall and kill, and accepts PC redirects for jumps and mispredicted branches.

---
 rtl/miriscv_fetch_stage.sv | 156 +++++++++++++++
 tb/tb_miriscv_fetch_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_fetch_stage.sv
// miriscv_fetch_stage
// Fetch stage of the miriscv pipeline. Holds the PC, issues in-order
// instruction memory requests over a req/gnt/rvalid handshake, buffers the
// returned words together with their PC and presents the head entry to decode.
// Obeys control-unit stall/kill and accepts PC redirects (force).
//
// Ports:
//   clk_i, arstn_i         clock, asynchronous active-low reset
//   cu_stall_f_i           decode cannot accept; head entry is held
//   cu_kill_f_i            flush buffer, discard every in-flight response
//   cu_force_f_i           kill plus load PC from cu_force_pc_i
//   cu_force_pc_i          redirect target
//   instr_req_o/addr_o     memory request and word-aligned address
//   instr_gnt_i            request accepted this cycle
//   instr_rvalid_i/rdata_i in-order response
//   f_instr_o              head instruction
//   f_current_pc_o         head PC
//   f_next_pc_o            head PC + 4
//   f_valid_o              head entry valid
module miriscv_fetch_stage #(
  parameter int unsigned       XLEN       = 32,
  parameter int unsigned       ILEN       = 32,
  parameter logic [XLEN-1:0]   RESET_PC   = 32'h8000_0000,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            cu_stall_f_i,
  input  logic            cu_kill_f_i,
  input  logic            cu_force_f_i,
  input  logic [XLEN-1:0] cu_force_pc_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [ILEN-1:0] instr_rdata_i,
  output logic [ILEN-1:0] f_instr_o,
  output logic [XLEN-1:0] f_current_pc_o,
  output logic [XLEN-1:0] f_next_pc_o,
  output logic            f_valid_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_count;

  logic [ILEN-1:0] r_bufInstr [FIFO_DEPTH];
  logic [XLEN-1:0] r_bufPc    [FIFO_DEPTH];
  logic [PW-1:0]   r_bufRd;
  logic [PW-1:0]   r_bufWr;

  // PC of every request that will still be pushed, recorded at grant time
  logic [XLEN-1:0] r_aqPc [FIFO_DEPTH];
  logic [PW-1:0]   r_aqRd;
  logic [PW-1:0]   r_aqWr;

  logic            w_flush;
  logic [CW:0]     w_credits;
  logic            w_req;
  logic            w_grant;
  logic            w_rvalidOk;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_inflightNext;
  logic [XLEN-1:0] w_addr;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_flush    = cu_kill_f_i | cu_force_f_i;
  assign w_addr     = r_pc & ~XLEN'(3);
  // A pop in this cycle only returns its credit once r_count updates
  assign w_credits  = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_req      = arstn_i & ~w_flush & (w_credits < (CW+1)'(FIFO_DEPTH));
  assign w_grant    = w_req & instr_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored
  assign w_rvalidOk = instr_rvalid_i & (r_inflight != '0);
  assign w_push     = w_rvalidOk & (r_discard == '0) & ~w_flush;
  assign w_pop      = (r_count != '0) & ~cu_stall_f_i & ~w_flush;
  assign w_inflightNext = r_inflight + CW'(w_grant) - CW'(w_rvalidOk);

  assign instr_req_o    = w_req;
  assign instr_addr_o   = w_addr;
  assign f_valid_o      = (r_count != '0);
  assign f_instr_o      = r_bufInstr[r_bufRd];
  assign f_current_pc_o = r_bufPc[r_bufRd];
  assign f_next_pc_o    = r_bufPc[r_bufRd] + XLEN'(4);

  // Control state. Kill/force wins over push and pop; every response still
  // outstanding after this cycle becomes one to discard, and the address
  // queue is emptied because none of those requests will be pushed.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_bufRd    <= '0;
      r_bufWr    <= '0;
      r_aqRd     <= '0;
      r_aqWr     <= '0;
    end else begin
      if (cu_force_f_i) begin
        r_pc <= cu_force_pc_i & ~XLEN'(3);
      end else if (w_grant) begin
        r_pc <= r_pc + XLEN'(4);
      end
      r_inflight <= w_inflightNext;
      if (w_flush) begin
        r_discard <= w_inflightNext;
        r_count   <= '0;
        r_bufRd   <= '0;
        r_bufWr   <= '0;
        r_aqRd    <= '0;
        r_aqWr    <= '0;
      end else begin
        if (w_rvalidOk && (r_discard != '0)) begin
          r_discard <= r_discard - CW'(1);
        end
        if (w_grant) begin
          r_aqWr <= nextPtr(r_aqWr);
        end
        if (w_push) begin
          r_aqRd  <= nextPtr(r_aqRd);
          r_bufWr <= nextPtr(r_bufWr);
        end
        if (w_pop) begin
          r_bufRd <= nextPtr(r_bufRd);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage needs no reset: entries are only read once marked valid
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      r_aqPc[r_aqWr] <= w_addr;
    end
    if (w_push) begin
      r_bufInstr[r_bufWr] <= instr_rdata_i;
      r_bufPc[r_bufWr]    <= r_aqPc[r_aqRd];
    end
  end

`ifndef SYNTHESIS
  a_noSpuriousRvalid: assert property (@(posedge clk_i) disable iff (!arstn_i)
    !(instr_rvalid_i && (r_inflight == '0)));
`endif

endmodule

// File: tb/tb_miriscv_fetch_stage.sv
// tb_miriscv_fetch_stage
// Directed bench for the fetch stage. A memory model answers granted requests
// in order with word {addr[15:0], 16'h0013}; a grant budget and a hold flag
// let the stimulus control exactly how many requests are accepted and when
// responses return. Expected fetches are queued by the stimulus and checked
// by a monitor whenever decode consumes an entry.
module tb_miriscv_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        cu_stall_f_i;
  logic        cu_kill_f_i;
  logic        cu_force_f_i;
  logic [31:0] cu_force_pc_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic [31:0] f_instr_o;
  logic [31:0] f_current_pc_o;
  logic [31:0] f_next_pc_o;
  logic        f_valid_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t      expQ[$];
  logic [31:0] pendingQ[$];
  int unsigned grantBudget = 0;
  bit          memHold = 1'b0;
  int          tests = 0;
  int          failures = 0;

  always #5 clk_i = ~clk_i;

  miriscv_fetch_stage #(
    .XLEN(32), .ILEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)
  ) dut (
    .clk_i(clk_i),
    .arstn_i(arstn_i),
    .cu_stall_f_i(cu_stall_f_i),
    .cu_kill_f_i(cu_kill_f_i),
    .cu_force_f_i(cu_force_f_i),
    .cu_force_pc_i(cu_force_pc_i),
    .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i),
    .f_instr_o(f_instr_o),
    .f_current_pc_o(f_current_pc_o),
    .f_next_pc_o(f_next_pc_o),
    .f_valid_o(f_valid_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic stall, input logic kill,
                               input logic force_, input logic [31:0] forcePc);
    @(posedge clk_i);
    #2;
    arstn_i       = rstn;
    cu_stall_f_i  = stall;
    cu_kill_f_i   = kill;
    cu_force_f_i  = force_;
    cu_force_pc_i = forcePc;
  endtask

  task automatic expectFetch(input logic [31:0] pc, input logic [31:0] instr);
    fetch_t e;
    e.pc    = pc;
    e.instr = instr;
    expQ.push_back(e);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (expQ.size() == 0) break;
      @(posedge clk_i);
      #2;
    end
    checkOutput({name, "Drained"}, 32'(expQ.size()), 32'd0);
    repeat (3) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic waitPending(input string name, input int n);
    for (int i = 0; i < 30; i++) begin
      if (pendingQ.size() == n) break;
      @(posedge clk_i);
      #2;
    end
    checkOutput(name, 32'(pendingQ.size()), 32'(n));
  endtask

  // Memory: a handshake seen before the edge is queued after it; the head
  // response is offered in the following cycle unless held.
  initial begin : memoryModel
    logic        sawGrant;
    logic [31:0] sawAddr;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    forever begin
      @(negedge clk_i);
      sawGrant = arstn_i && instr_req_o && instr_gnt_i;
      sawAddr  = instr_addr_o;
      @(posedge clk_i);
      #1;
      if (!arstn_i) begin
        pendingQ.delete();
        instr_rvalid_i = 1'b0;
      end else begin
        if (sawGrant) begin
          pendingQ.push_back(sawAddr);
          if (grantBudget > 0) grantBudget--;
        end
        if (!memHold && pendingQ.size() > 0) begin
          instr_rdata_i  = {pendingQ[0][15:0], 16'h0013};
          instr_rvalid_i = 1'b1;
          void'(pendingQ.pop_front());
        end else begin
          instr_rdata_i  = 32'hDEAD_BEEF;
          instr_rvalid_i = 1'b0;
        end
      end
      instr_gnt_i = (grantBudget > 0);
    end
  end

  // Monitor: every entry decode consumes must be the next expected fetch
  initial begin : monitor
    fetch_t e;
    forever begin
      @(negedge clk_i);
      if (arstn_i && f_valid_o && !cu_stall_f_i && !cu_kill_f_i && !cu_force_f_i) begin
        if (expQ.size() == 0) begin
          tests++;
          failures++;
          $display("[TB] FAIL unexpectedFetch: got pc=%h instr=%h, required no fetch",
                   f_current_pc_o, f_instr_o);
        end else begin
          e = expQ.pop_front();
          checkOutput("fetchPc", f_current_pc_o, e.pc);
          checkOutput("fetchNextPc", f_next_pc_o, e.pc + 32'd4);
          checkOutput("fetchInstr", f_instr_o, e.instr);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required completion within 20000 cycles");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    arstn_i       = 1'b0;
    cu_stall_f_i  = 1'b1;
    cu_kill_f_i   = 1'b0;
    cu_force_f_i  = 1'b0;
    cu_force_pc_i = 32'h0;
    grantBudget   = 2;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("resetReq", 32'(instr_req_o), 32'd0);
    checkOutput("resetValid", 32'(f_valid_o), 32'd0);
    checkOutput("resetAddr", instr_addr_o, RESET_PC);

    // First fetches, decode stalled so the buffer fills
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    checkOutput("firstReq", 32'(instr_req_o), 32'd1);
    checkOutput("firstAddr", instr_addr_o, 32'h8000_0000);
    @(negedge clk_i);
    checkOutput("secondReq", 32'(instr_req_o), 32'd1);
    checkOutput("secondAddr", instr_addr_o, 32'h8000_0004);
    @(negedge clk_i);
    checkOutput("headValid", 32'(f_valid_o), 32'd1);
    checkOutput("headPc", f_current_pc_o, 32'h8000_0000);
    checkOutput("headNextPc", f_next_pc_o, 32'h8000_0004);
    checkOutput("headInstr", f_instr_o, 32'h0000_0013);
    repeat (4) begin
      @(negedge clk_i);
      checkOutput("stallNoReq", 32'(instr_req_o), 32'd0);
      checkOutput("stallValid", 32'(f_valid_o), 32'd1);
      checkOutput("stallHeadPc", f_current_pc_o, 32'h8000_0000);
    end
    expectFetch(32'h8000_0000, 32'h0000_0013);
    expectFetch(32'h8000_0004, 32'h0004_0013);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    waitDrain("stream");

    // No grant: request held at a stable address
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("holdReq", 32'(instr_req_o), 32'd1);
      checkOutput("holdAddr", instr_addr_o, 32'h8000_0008);
    end

    // Redirect with two requests in flight
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    grantBudget = 2;
    memHold     = 1'b1;
    waitPending("forceInflight", 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0102);
    @(negedge clk_i);
    checkOutput("forceNoReq", 32'(instr_req_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    checkOutput("forceAddr", instr_addr_o, 32'h8000_0100);
    checkOutput("forceValid", 32'(f_valid_o), 32'd0);
    expectFetch(32'h8000_0100, 32'h0100_0013);
    expectFetch(32'h8000_0104, 32'h0104_0013);
    grantBudget = 2;
    memHold     = 1'b0;
    waitDrain("redirect");

    // Kill in the same cycle as a response
    grantBudget = 2;
    memHold     = 1'b1;
    waitPending("killInflight", 2);
    memHold = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    memHold = 1'b1;
    @(negedge clk_i);
    checkOutput("killNoReq", 32'(instr_req_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    checkOutput("killValid", 32'(f_valid_o), 32'd0);
    checkOutput("killResumeReq", 32'(instr_req_o), 32'd1);
    checkOutput("killResumeAddr", instr_addr_o, 32'h8000_0110);
    expectFetch(32'h8000_0110, 32'h0110_0013);
    expectFetch(32'h8000_0114, 32'h0114_0013);
    grantBudget = 2;
    memHold     = 1'b0;
    waitDrain("kill");

    // Reset with one entry buffered and one in flight
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    grantBudget = 1;
    repeat (6) begin
      @(posedge clk_i);
      #2;
    end
    memHold     = 1'b1;
    grantBudget = 1;
    waitPending("rstInflight", 1);
    @(negedge clk_i);
    checkOutput("rstPreValid", 32'(f_valid_o), 32'd1);
    checkOutput("rstPrePc", f_current_pc_o, 32'h8000_0118);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("rstValid", 32'(f_valid_o), 32'd0);
    checkOutput("rstReq", 32'(instr_req_o), 32'd0);
    checkOutput("rstAddr", instr_addr_o, RESET_PC);
    expectFetch(32'h8000_0000, 32'h0000_0013);
    expectFetch(32'h8000_0004, 32'h0004_0013);
    grantBudget = 2;
    memHold     = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    checkOutput("postRstReq", 32'(instr_req_o), 32'd1);
    checkOutput("postRstAddr", instr_addr_o, 32'h8000_0000);
    waitDrain("afterReset");

    // Kill a full buffer while stalled
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    grantBudget = 2;
    repeat (8) begin
      @(posedge clk_i);
      #2;
    end
    @(negedge clk_i);
    checkOutput("fullValid", 32'(f_valid_o), 32'd1);
    checkOutput("fullPc", f_current_pc_o, 32'h8000_0008);
    checkOutput("fullNoReq", 32'(instr_req_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    checkOutput("flushValid", 32'(f_valid_o), 32'd0);
    checkOutput("flushReq", 32'(instr_req_o), 32'd1);
    checkOutput("flushAddr", instr_addr_o, 32'h8000_0010);
    expectFetch(32'h8000_0010, 32'h0010_0013);
    expectFetch(32'h8000_0014, 32'h0014_0013);
    grantBudget = 2;
    waitDrain("flush");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
